// File: rtl/mmio_io_unit.sv
// mmio_io_unit: memory-mapped I/O slave for the RV32I MEM stage.
// Four word registers live in a 16-byte window at IO_BASE: OUT latch,
// synchronized IN, sticky rising-edge flags (W1C) and a free-running timer.
// Read data is registered so it lines up with data memory's registered q.
module mmio_io_unit #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] IO_BASE  = 32'h0000_0200,
  parameter int          IO_WIDTH = 11
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [XLEN-1:0]     address,
  input  logic [XLEN-1:0]     wdata,
  input  logic                wren,
  output logic                io_hit,
  output logic [XLEN-1:0]     rdata,
  output logic                rdata_is_io,
  input  logic [IO_WIDTH-1:0] io_input_bus,
  output logic [IO_WIDTH-1:0] io_output_bus
);

  localparam logic [XLEN-1:0] BASE = XLEN'(IO_BASE);

  logic [IO_WIDTH-1:0] r_out;
  logic [IO_WIDTH-1:0] r_sync1, r_sync2, r_sync3;
  logic [IO_WIDTH-1:0] r_edge;
  logic [31:0]         r_timer;
  logic [XLEN-1:0]     r_rdata;
  logic                r_rdata_is_io;

  logic                w_wr;
  logic [1:0]          w_ofs;
  logic [IO_WIDTH-1:0] w_w1c;
  logic [IO_WIDTH-1:0] w_rise;
  logic [XLEN-1:0]     w_rmux;

  assign io_hit        = (address[XLEN-1:4] == BASE[XLEN-1:4]);
  assign w_ofs         = address[3:2];
  assign w_wr          = wren & io_hit;
  assign w_rise        = r_sync2 & ~r_sync3;
  assign w_w1c         = (w_wr && w_ofs == 2'd2) ? wdata[IO_WIDTH-1:0] : '0;
  assign rdata         = r_rdata;
  assign rdata_is_io   = r_rdata_is_io;
  assign io_output_bus = r_out;

  // Read mux over pre-edge register values; IN reads sync2, not sync1
  always_comb begin
    w_rmux = '0;
    if (io_hit) begin
      case (w_ofs)
        2'd0:    w_rmux = {{(XLEN-IO_WIDTH){1'b0}}, r_out};
        2'd1:    w_rmux = {{(XLEN-IO_WIDTH){1'b0}}, r_sync2};
        2'd2:    w_rmux = {{(XLEN-IO_WIDTH){1'b0}}, r_edge};
        default: w_rmux = XLEN'(r_timer);
      endcase
    end
  end

  // Registered read path, updated every cycle (no read enable)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata       <= '0;
      r_rdata_is_io <= 1'b0;
    end else begin
      r_rdata       <= w_rmux;
      r_rdata_is_io <= io_hit;
    end
  end

  // Output latch; full-word stores only, upper bits dropped
  always_ff @(posedge clock) begin
    if (reset)                      r_out <= '0;
    else if (w_wr && w_ofs == 2'd0) r_out <= wdata[IO_WIDTH-1:0];
  end

  // Three-flop input chain: sync1/sync2 resolve metastability, sync3 is the edge history
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= io_input_bus;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Sticky rising-edge flags; a coincident set beats the write-1-to-clear
  always_ff @(posedge clock) begin
    if (reset) r_edge <= '0;
    else       r_edge <= (r_edge & ~w_w1c) | w_rise;
  end

  // Free-running timer; a store replaces that cycle's increment
  always_ff @(posedge clock) begin
    if (reset)                      r_timer <= '0;
    else if (w_wr && w_ofs == 2'd3) r_timer <= wdata[31:0];
    else                            r_timer <= r_timer + 32'd1;
  end

endmodule

// File: tb/tb_mmio_io_unit.sv
// Scoreboard bench for mmio_io_unit: the driver computes expected registered
// outputs from a register-map model and queues them; a monitor compares.
module tb_mmio_io_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic        wren = 1'b0;
  logic        io_hit;
  logic [31:0] rdata;
  logic        rdata_is_io;
  logic [10:0] io_input_bus = '0;
  logic [10:0] io_output_bus;

  mmio_io_unit dut (
    .clock(clock), .reset(reset), .address(address), .wdata(wdata), .wren(wren),
    .io_hit(io_hit), .rdata(rdata), .rdata_is_io(rdata_is_io),
    .io_input_bus(io_input_bus), .io_output_bus(io_output_bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rd;
    logic        io;
    logic [10:0] bus;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          errors  = 0;

  // model state: register contents, timer as base + elapsed edges, input sample history
  logic [10:0] m_out  = '0;
  logic [10:0] m_edge = '0;
  logic [31:0] t_base = '0;
  logic [31:0] t_cyc  = '0;
  logic [31:0] cyc    = '0;
  logic [10:0] smp[$] = '{11'd0, 11'd0, 11'd0};
  logic [10:0] cur_ib = '0;

  task automatic model_step(input bit rst, input logic [31:0] a, input logic [31:0] wd,
                            input bit we, input logic [10:0] ib);
    exp_t        e;
    bit          hit;
    int          ofs;
    logic [10:0] in_now, in_prev, w1c;
    logic [31:0] tnow;
    hit     = (a >= 32'h200) && (a < 32'h210);
    ofs     = int'((a - 32'h200) >> 2) & 3;
    in_now  = smp[smp.size()-2];   // sampled two edges ago
    in_prev = smp[smp.size()-3];   // sampled three edges ago
    tnow    = t_base + (cyc - t_cyc);
    if (rst) begin
      e.rd = '0; e.io = 1'b0;
      m_out = '0; m_edge = '0; t_base = '0; t_cyc = cyc + 1;
      smp.push_back('0); smp.push_back('0); smp.push_back('0);
    end else begin
      e.io = hit;
      e.rd = '0;
      if (hit) begin
        case (ofs)
          0: e.rd = {21'd0, m_out};
          1: e.rd = {21'd0, in_now};
          2: e.rd = {21'd0, m_edge};
          default: e.rd = tnow;
        endcase
      end
      w1c    = (hit && we && ofs == 2) ? wd[10:0] : 11'd0;
      m_edge = (m_edge & ~w1c) | (in_now & ~in_prev);
      if (hit && we && ofs == 0) m_out = wd[10:0];
      if (hit && we && ofs == 3) begin t_base = wd; t_cyc = cyc + 1; end
      smp.push_back(ib);
    end
    e.bus = m_out;
    while (smp.size() > 8) void'(smp.pop_front());
    cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic drv(input bit rst, input logic [31:0] a, input logic [31:0] wd, input bit we);
    bit exp_hit;
    @(negedge clock);
    reset = rst; address = a; wdata = wd; wren = we; io_input_bus = cur_ib;
    #1;
    exp_hit = (a >= 32'h200) && (a < 32'h210);
    vectors++;
    if (io_hit !== exp_hit) begin
      errors++;
      $display("FAIL io_hit addr=%h got=%b exp=%b", a, io_hit, exp_hit);
    end
    model_step(rst, a, wd, we, cur_ib);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 32'h0000_0100, 32'h0, 1'b0);
  endtask

  // monitor: registered outputs checked just after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (rdata !== e.rd || rdata_is_io !== e.io || io_output_bus !== e.bus) begin
          errors++;
          $display("FAIL rd_out t=%0t rdata=%h/%h is_io=%b/%b bus=%h/%h (got/exp)",
                   $time, rdata, e.rd, rdata_is_io, e.io, io_output_bus, e.bus);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, wd;
    // reset, OUT store and readback
    drv(1, 32'h200, 32'h0, 0); drv(1, 32'h200, 32'h0, 0);
    drv(0, 32'h200, 32'h0000_05A5, 1);
    drv(0, 32'h200, 32'h0, 0);
    idle(1);
    // out-of-window store
    drv(0, 32'h1FC, 32'hFFFF_FFFF, 1);
    drv(0, 32'h1FC, 32'h0, 0);
    drv(0, 32'h210, 32'h0000_0111, 1);
    drv(0, 32'h200, 32'h0, 0);
    // input synchronizer and edge flags
    cur_ib = 11'h003;
    for (int i = 0; i < 4; i++) drv(0, 32'h204, 32'h0, 0);
    drv(0, 32'h208, 32'h0, 0); drv(0, 32'h208, 32'h0, 0);
    drv(0, 32'h208, 32'h1, 1);
    drv(0, 32'h208, 32'h0, 0);
    // re-pulse bit 0 so its set lands on the W1C edge
    cur_ib = 11'h002; idle(4);
    cur_ib = 11'h003; idle(2);
    drv(0, 32'h20A, 32'h1, 1);
    drv(0, 32'h208, 32'h0, 0); drv(0, 32'h208, 32'h0, 0);
    // timer after reset and wrap
    drv(1, 32'h0, 32'h0, 0);
    idle(10);
    drv(0, 32'h20C, 32'h0, 0);
    drv(0, 32'h20C, 32'hFFFF_FFFE, 1);
    for (int i = 0; i < 4; i++) drv(0, 32'h20C, 32'h0, 0);
    // IN is read-only; reset beats a same-cycle store
    drv(0, 32'h204, 32'h0000_07FF, 1);
    drv(0, 32'h204, 32'h0, 0);
    drv(1, 32'h200, 32'h0000_0123, 1);
    drv(0, 32'h200, 32'h0, 0); drv(0, 32'h208, 32'h0, 0); drv(0, 32'h20C, 32'h0, 0);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 32'h3FF);
      else                           a = 32'h200 + $urandom_range(0, 15);
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) wd = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) cur_ib = cur_ib ^ 11'($urandom);
      drv($urandom_range(0, 99) == 0, a, wd, $urandom_range(0, 2) == 0);
    end
    idle(1);
    repeat (3) @(negedge clock);
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
